// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and helpers for the VGA raster path.
//   DEF_*      : default 640x480@60 Hz timing (clocks for horizontal, lines
//                for vertical)
//   CNT_W      : width of the raster counters
//   COORD_W    : width of the published pixel coordinates
//   region_e   : which part of a line/frame a counter value falls in
//   getRegion  : maps a counter value to its region given the four widths
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_V_FRONT = 10;

    localparam int CNT_W   = 12;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        REGION_SYNC,
        REGION_BACK,
        REGION_ACTIVE,
        REGION_FRONT
    } region_e;

    // Regions are laid out sync, back porch, active, front porch from count 0.
    // A count past the end of the front porch cannot occur while the counter
    // wraps correctly; it is treated as the start of the next line.
    function automatic region_e getRegion(input int cnt,
                                          input int syncW,
                                          input int backW,
                                          input int actW,
                                          input int frontW);
        region_e region;
        if (cnt < syncW) begin
            region = REGION_SYNC;
        end else if (cnt < syncW + backW) begin
            region = REGION_BACK;
        end else if (cnt < syncW + backW + actW) begin
            region = REGION_ACTIVE;
        end else if (cnt < syncW + backW + actW + frontW) begin
            region = REGION_FRONT;
        end else begin
            region = REGION_SYNC;
        end
        return region;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ----------------------------------------------------------------------------
// vga_delay_line
// DEPTH-stage shift register, WIDTH bits wide, asynchronously reset to
// RESET_VAL in every stage.
//   clock_i : shift clock
//   rstN_i  : asynchronous active-low reset
//   din_i   : value entering stage 0
//   tap_o   : value about to enter the final stage (one clock ahead of dout_o)
//   dout_o  : final stage, din_i delayed by DEPTH clocks
// ----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock_i,
    input  logic             rstN_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] tap_o,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Plain shift chain; every stage returns to RESET_VAL on reset so nothing
    // stale drains out after release.
    always_ff @(posedge clock_i or negedge rstN_i) begin
        if (!rstN_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

    // The tap lets a companion register load in lockstep with the final stage.
    generate
        if (DEPTH == 1) begin : gTapDirect
            assign tap_o = din_i;
        end else begin : gTapStage
            assign tap_o = stage_q[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
// Raster timing master for the VGA output path. Runs the horizontal and
// vertical counters, publishes the coordinates of the next visible pixel to a
// pixel source, takes that source's RGB PIX_LAT clocks later and re-aligns it
// with delayed sync/blank for the DAC.
//   iVGA_CLK        : pixel clock
//   iRST_n          : asynchronous active-low reset
//   oVGA_X/oVGA_Y   : active-area column/row, 0 outside the active area
//   oRequest        : oVGA_X/oVGA_Y name a visible pixel
//   oFrameStart     : one-clock pulse with the request for pixel (0,0)
//   iRed/iGreen/iBlue : pixel source RGB, valid PIX_LAT clocks after request
//   oVGA_R/G/B      : RGB to the DAC, forced to 0 while blanked
//   oVGA_HS/oVGA_VS : sync, active level SYNC_POL
//   oVGA_BLANK_n    : low during blanking
//   oVGA_SYNC_n     : tied low, no sync-on-green
// ----------------------------------------------------------------------------
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_ACT    = DEF_H_ACT,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_ACT    = DEF_V_ACT,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   PIX_LAT  = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         iVGA_CLK,
    input  logic         iRST_n,
    output logic [9:0]   oVGA_X,
    output logic [9:0]   oVGA_Y,
    output logic         oRequest,
    output logic         oFrameStart,
    input  logic [9:0]   iRed,
    input  logic [9:0]   iGreen,
    input  logic [9:0]   iBlue,
    output logic [9:0]   oVGA_R,
    output logic [9:0]   oVGA_G,
    output logic [9:0]   oVGA_B,
    output logic         oVGA_HS,
    output logic         oVGA_VS,
    output logic         oVGA_BLANK_n,
    output logic         oVGA_SYNC_n
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ORIGIN = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_ORIGIN = CNT_W'(V_SYNC + V_BACK);

    localparam logic       SYNC_IDLE = ~SYNC_POL;
    localparam int         DLY_DEPTH = PIX_LAT + 1;
    // Delay-line word is {hs, vs, blank_n}.
    localparam logic [2:0] DLY_RESET = {SYNC_IDLE, SYNC_IDLE, 1'b0};

    logic [CNT_W-1:0] hCnt_q, hCnt_d;
    logic [CNT_W-1:0] vCnt_q, vCnt_d;

    region_e hRegion, vRegion;

    logic               request_q, request_d;
    logic               frameStart_q, frameStart_d;
    logic               hsRaw_q, hsRaw_d;
    logic               vsRaw_q, vsRaw_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    logic [2:0]  alignTap;
    logic [2:0]  alignOut;
    logic [29:0] rgb_q, rgb_d;

    // Raster counters: the line counter steps only when the pixel counter
    // wraps, so the last pixel of the last line returns both to 0 together.
    always_comb begin
        hCnt_d = hCnt_q + CNT_W'(1);
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            if (vCnt_q == V_LAST) begin
                vCnt_d = '0;
            end else begin
                vCnt_d = vCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    assign hRegion = getRegion(int'(hCnt_q), H_SYNC, H_BACK, H_ACT, H_FRONT);
    assign vRegion = getRegion(int'(vCnt_q), V_SYNC, V_BACK, V_ACT, V_FRONT);

    // Stage 1 decode: request, coordinates and raw sync all come from the
    // same counter value so they stay mutually consistent.
    always_comb begin
        request_d = (hRegion == REGION_ACTIVE) && (vRegion == REGION_ACTIVE);
        x_d       = '0;
        y_d       = '0;
        if (request_d) begin
            x_d = COORD_W'(hCnt_q - H_ORIGIN);
            y_d = COORD_W'(vCnt_q - V_ORIGIN);
        end
        frameStart_d = request_d && (x_d == '0) && (y_d == '0);
        hsRaw_d      = (hRegion == REGION_SYNC) ? SYNC_POL : SYNC_IDLE;
        vsRaw_d      = (vRegion == REGION_SYNC) ? SYNC_POL : SYNC_IDLE;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            request_q    <= 1'b0;
            frameStart_q <= 1'b0;
            hsRaw_q      <= SYNC_IDLE;
            vsRaw_q      <= SYNC_IDLE;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            request_q    <= request_d;
            frameStart_q <= frameStart_d;
            hsRaw_q      <= hsRaw_d;
            vsRaw_q      <= vsRaw_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    // Sync and blank wait PIX_LAT+1 clocks so they land with the RGB that the
    // source returns for the same pixel. Blank_n is simply the stage-1 request.
    vga_delay_line #(
        .DEPTH     (DLY_DEPTH),
        .WIDTH     (3),
        .RESET_VAL (DLY_RESET)
    ) uAlign (
        .clock_i (iVGA_CLK),
        .rstN_i  (iRST_n),
        .din_i   ({hsRaw_q, vsRaw_q, request_q}),
        .tap_o   (alignTap),
        .dout_o  (alignOut)
    );

    // RGB is captured on the same edge the delayed blank_n reaches the output,
    // gated by the blank_n value loading alongside it, so nothing from the
    // source leaks through outside a visible pixel.
    always_comb begin
        rgb_d = '0;
        if (alignTap[0]) begin
            rgb_d = {iRed, iGreen, iBlue};
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign oVGA_X       = x_q;
    assign oVGA_Y       = y_q;
    assign oRequest     = request_q;
    assign oFrameStart  = frameStart_q;
    assign oVGA_R       = rgb_q[29:20];
    assign oVGA_G       = rgb_q[19:10];
    assign oVGA_B       = rgb_q[9:0];
    assign oVGA_HS      = alignOut[2];
    assign oVGA_VS      = alignOut[1];
    assign oVGA_BLANK_n = alignOut[0];
    assign oVGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl
// Drives two copies of vga_timing_ctrl with a shrunken raster so whole frames
// fit in a short run:
//   H: sync 2, back 3, active 4, front 1  -> 10 clocks per line
//   V: sync 2, back 1, active 3, front 1  -> 7 lines, 70 clocks per frame
// Copy A uses PIX_LAT=1 with active-low sync, copy B PIX_LAT=3 with
// active-high sync. Each has a pixel source with the matching latency that
// returns a coordinate-derived colour for requested pixels and all-ones
// otherwise.
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    int vectorCount = 0;
    int missCount   = 0;

    logic [9:0] xA, yA, rA, gA, bA;
    logic       reqA, fsA, hsA, vsA, blankA, syncNA;
    logic [9:0] xB, yB, rB, gB, bB;
    logic       reqB, fsB, hsB, vsB, blankB, syncNB;

    logic [29:0] srcA  = '1;
    logic [29:0] srcB0 = '1;
    logic [29:0] srcB1 = '1;
    logic [29:0] srcB2 = '1;

    // Free-running pixel clock.
    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_SYNC(2), .H_BACK(3), .H_ACT(4), .H_FRONT(1),
        .V_SYNC(2), .V_BACK(1), .V_ACT(3), .V_FRONT(1),
        .PIX_LAT(1), .SYNC_POL(1'b0)
    ) dutA (
        .iVGA_CLK(clk), .iRST_n(rstN),
        .oVGA_X(xA), .oVGA_Y(yA), .oRequest(reqA), .oFrameStart(fsA),
        .iRed(srcA[29:20]), .iGreen(srcA[19:10]), .iBlue(srcA[9:0]),
        .oVGA_R(rA), .oVGA_G(gA), .oVGA_B(bA),
        .oVGA_HS(hsA), .oVGA_VS(vsA), .oVGA_BLANK_n(blankA), .oVGA_SYNC_n(syncNA)
    );

    vga_timing_ctrl #(
        .H_SYNC(2), .H_BACK(3), .H_ACT(4), .H_FRONT(1),
        .V_SYNC(2), .V_BACK(1), .V_ACT(3), .V_FRONT(1),
        .PIX_LAT(3), .SYNC_POL(1'b1)
    ) dutB (
        .iVGA_CLK(clk), .iRST_n(rstN),
        .oVGA_X(xB), .oVGA_Y(yB), .oRequest(reqB), .oFrameStart(fsB),
        .iRed(srcB2[29:20]), .iGreen(srcB2[19:10]), .iBlue(srcB2[9:0]),
        .oVGA_R(rB), .oVGA_G(gB), .oVGA_B(bB),
        .oVGA_HS(hsB), .oVGA_VS(vsB), .oVGA_BLANK_n(blankB), .oVGA_SYNC_n(syncNB)
    );

    // Colour for a pixel: red = {x[4:0],y[4:0]} ^ 0x2AA, green = ~red,
    // blue = {y[4:0],x[4:0]}. Pixel (0,0) -> red 0x2AA, green 0x155.
    function automatic logic [29:0] pixelRgb(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] red;
        red = {x[4:0], y[4:0]} ^ 10'h2AA;
        return {red, ~red, {y[4:0], x[4:0]}};
    endfunction

    // Pixel sources: one register for latency 1, three for latency 3.
    always @(posedge clk) begin
        srcA  <= reqA ? pixelRgb(xA, yA) : '1;
        srcB0 <= reqB ? pixelRgb(xB, yB) : '1;
        srcB1 <= srcB0;
        srcB2 <= srcB1;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Every output of both copies must sit at its reset value.
    task automatic checkResetValues(input string when);
        checkOutput({when, ":xA"},     32'(xA),     32'h0);
        checkOutput({when, ":yA"},     32'(yA),     32'h0);
        checkOutput({when, ":reqA"},   32'(reqA),   32'h0);
        checkOutput({when, ":fsA"},    32'(fsA),    32'h0);
        checkOutput({when, ":rgbA"},   32'({rA, gA, bA}), 32'h0);
        checkOutput({when, ":hsA"},    32'(hsA),    32'h1);
        checkOutput({when, ":vsA"},    32'(vsA),    32'h1);
        checkOutput({when, ":blankA"}, 32'(blankA), 32'h0);
        checkOutput({when, ":syncNA"}, 32'(syncNA), 32'h0);
        checkOutput({when, ":reqB"},   32'(reqB),   32'h0);
        checkOutput({when, ":xyB"},    32'({xB, yB}), 32'h0);
        checkOutput({when, ":fsB"},    32'(fsB),    32'h0);
        checkOutput({when, ":rgbB"},   32'({rB, gB, bB}), 32'h0);
        checkOutput({when, ":hsB"},    32'(hsB),    32'h0);
        checkOutput({when, ":vsB"},    32'(vsB),    32'h0);
        checkOutput({when, ":blankB"}, 32'(blankB), 32'h0);
        checkOutput({when, ":syncNB"}, 32'(syncNB), 32'h0);
    endtask

    // Runs two frames from reset release (edge 1 is the first rising edge
    // after release), checking hand-computed values at chosen edges and
    // per-frame totals over edges 71..140.
    task automatic applyStimulus(input string phase);
        int hsCntA = 0, vsCntA = 0, blankCntA = 0, reqCntA = 0, fsCntA = 0;
        int vsRunA = 0, vsMaxA = 0, earlyBlankA = 0, leakA = 0;
        int hsCntB = 0, vsCntB = 0, blankCntB = 0, fsCntB = 0, leakB = 0;
        @(negedge clk);
        rstN = 1'b1;
        for (int e = 1; e <= 140; e++) begin
            @(posedge clk);
            #1;
            case (e)
                2:  checkOutput({phase, ":hsA@2"}, 32'(hsA), 32'h1);
                3:  checkOutput({phase, ":hsA@3"}, 32'(hsA), 32'h0);
                4:  checkOutput({phase, ":hsB@4"}, 32'(hsB), 32'h0);
                5: begin
                    checkOutput({phase, ":hsA@5"}, 32'(hsA), 32'h1);
                    checkOutput({phase, ":hsB@5"}, 32'(hsB), 32'h1);
                end
                7:  checkOutput({phase, ":hsB@7"}, 32'(hsB), 32'h0);
                22: checkOutput({phase, ":vsA@22"}, 32'(vsA), 32'h0);
                23: checkOutput({phase, ":vsA@23"}, 32'(vsA), 32'h1);
                35: checkOutput({phase, ":reqA@35"}, 32'(reqA), 32'h0);
                36: begin
                    checkOutput({phase, ":reqA@36"}, 32'(reqA), 32'h1);
                    checkOutput({phase, ":xyA@36"}, 32'({xA, yA}), 32'h0);
                    checkOutput({phase, ":fsA@36"}, 32'(fsA), 32'h1);
                    checkOutput({phase, ":fsB@36"}, 32'(fsB), 32'h1);
                end
                37: begin
                    checkOutput({phase, ":xA@37"}, 32'(xA), 32'h1);
                    checkOutput({phase, ":fsA@37"}, 32'(fsA), 32'h0);
                    checkOutput({phase, ":blankA@37"}, 32'(blankA), 32'h0);
                    checkOutput({phase, ":rA@37"}, 32'(rA), 32'h0);
                end
                38: begin
                    checkOutput({phase, ":blankA@38"}, 32'(blankA), 32'h1);
                    checkOutput({phase, ":rA@38"}, 32'(rA), 32'h2AA);
                    checkOutput({phase, ":gA@38"}, 32'(gA), 32'h155);
                    checkOutput({phase, ":xB@38"}, 32'(xB), 32'h2);
                end
                39: begin
                    checkOutput({phase, ":xA@39"}, 32'(xA), 32'h3);
                    checkOutput({phase, ":blankB@39"}, 32'(blankB), 32'h0);
                    checkOutput({phase, ":rB@39"}, 32'(rB), 32'h0);
                end
                40: begin
                    checkOutput({phase, ":reqA@40"}, 32'(reqA), 32'h0);
                    checkOutput({phase, ":xA@40"}, 32'(xA), 32'h0);
                    checkOutput({phase, ":blankB@40"}, 32'(blankB), 32'h1);
                    checkOutput({phase, ":rB@40"}, 32'(rB), 32'h2AA);
                end
                41: begin
                    checkOutput({phase, ":blankA@41"}, 32'(blankA), 32'h1);
                    checkOutput({phase, ":rA@41"}, 32'(rA), 32'h2CA);
                    checkOutput({phase, ":gA@41"}, 32'(gA), 32'h135);
                end
                42: begin
                    checkOutput({phase, ":blankA@42"}, 32'(blankA), 32'h0);
                    checkOutput({phase, ":rA@42"}, 32'(rA), 32'h0);
                end
                46: begin
                    checkOutput({phase, ":reqA@46"}, 32'(reqA), 32'h1);
                    checkOutput({phase, ":xyA@46"}, 32'({xA, yA}), 32'({10'd0, 10'd1}));
                    checkOutput({phase, ":fsA@46"}, 32'(fsA), 32'h0);
                end
                59: begin
                    checkOutput({phase, ":reqA@59"}, 32'(reqA), 32'h1);
                    checkOutput({phase, ":xyA@59"}, 32'({xA, yA}), 32'({10'd3, 10'd2}));
                end
                60: checkOutput({phase, ":reqA@60"}, 32'(reqA), 32'h0);
                66: begin
                    checkOutput({phase, ":reqA@66"}, 32'(reqA), 32'h0);
                    checkOutput({phase, ":yA@66"}, 32'(yA), 32'h0);
                end
                106: begin
                    checkOutput({phase, ":fsA@106"}, 32'(fsA), 32'h1);
                    checkOutput({phase, ":xyA@106"}, 32'({xA, yA}), 32'h0);
                end
                default: ;
            endcase
            if (e <= 37 && blankA) earlyBlankA++;
            if (!blankA && ({rA, gA, bA} != 30'd0)) leakA++;
            if (!blankB && ({rB, gB, bB} != 30'd0)) leakB++;
            if (e > 70) begin
                if (!hsA) hsCntA++;
                if (!vsA) vsCntA++;
                if (blankA) blankCntA++;
                if (reqA) reqCntA++;
                if (fsA) fsCntA++;
                if (hsB) hsCntB++;
                if (vsB) vsCntB++;
                if (blankB) blankCntB++;
                if (fsB) fsCntB++;
                vsRunA = vsA ? 0 : vsRunA + 1;
                if (vsRunA > vsMaxA) vsMaxA = vsRunA;
            end
        end
        checkOutput({phase, ":earlyBlankA"}, 32'(earlyBlankA), 32'd0);
        checkOutput({phase, ":leakA"}, 32'(leakA), 32'd0);
        checkOutput({phase, ":leakB"}, 32'(leakB), 32'd0);
        checkOutput({phase, ":hsClocksA"}, 32'(hsCntA), 32'd14);
        checkOutput({phase, ":vsClocksA"}, 32'(vsCntA), 32'd20);
        checkOutput({phase, ":vsRunA"}, 32'(vsMaxA), 32'd20);
        checkOutput({phase, ":blankClocksA"}, 32'(blankCntA), 32'd12);
        checkOutput({phase, ":reqClocksA"}, 32'(reqCntA), 32'd12);
        checkOutput({phase, ":fsPulsesA"}, 32'(fsCntA), 32'd1);
        checkOutput({phase, ":hsClocksB"}, 32'(hsCntB), 32'd14);
        checkOutput({phase, ":vsClocksB"}, 32'(vsCntB), 32'd20);
        checkOutput({phase, ":blankClocksB"}, 32'(blankCntB), 32'd12);
        checkOutput({phase, ":fsPulsesB"}, 32'(fsCntB), 32'd1);
    endtask

    // Power-on reset, two frames, a reset dropped in the middle of a visible
    // pixel, then two more frames to confirm a clean restart.
    initial begin
        $display("[TB] start");
        repeat (4) @(posedge clk);
        #1;
        checkResetValues("powerOn");
        applyStimulus("run1");
        repeat (38) @(posedge clk);
        #1;
        checkOutput("preReset:blankA@178", 32'(blankA), 32'h1);
        checkOutput("preReset:rA@178", 32'(rA), 32'h2AA);
        #2;
        rstN = 1'b0;
        #1;
        checkResetValues("midLine");
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("held");
        applyStimulus("run2");
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
